// File: rtl/alu_issue_ctrl_if.sv
// Bundle of fetch, register-file, ALU, writeback, branch and memory signals
// around the ALU issue controller; clk and rst stay outside as plain ports.
interface alu_issue_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             instr_valid;
    logic             instr_ready;
    logic [31:0]      instr;
    logic [4:0]       rf_raddr1;
    logic [4:0]       rf_raddr2;
    logic [WIDTH-1:0] rf_rdata1;
    logic [WIDTH-1:0] rf_rdata2;
    logic [6:0]       alu_opcode;
    logic [2:0]       alu_funct3;
    logic [6:0]       alu_funct7;
    logic [11:0]      alu_imm;
    logic [4:0]       alu_shamt;
    logic [WIDTH-1:0] alu_rs1;
    logic [WIDTH-1:0] alu_rs2;
    logic [WIDTH-1:0] alu_rd;
    logic [WIDTH-1:0] alu_mem_addr;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [WIDTH-1:0] rf_wdata;
    logic             br_valid;
    logic             br_taken;
    logic             mem_req_valid;
    logic             mem_req_we;
    logic [WIDTH-1:0] mem_req_addr;
    logic [WIDTH-1:0] mem_req_wdata;
    logic             illegal;
    logic             busy;
    logic [31:0]      retired_count;

    modport slave (
        input  instr_valid, instr, rf_rdata1, rf_rdata2, alu_rd, alu_mem_addr,
        output instr_ready, rf_raddr1, rf_raddr2,
               alu_opcode, alu_funct3, alu_funct7, alu_imm, alu_shamt, alu_rs1, alu_rs2,
               rf_we, rf_waddr, rf_wdata, br_valid, br_taken,
               mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
               illegal, busy, retired_count
    );

    modport master (
        output instr_valid, instr, rf_rdata1, rf_rdata2, alu_rd, alu_mem_addr,
        input  instr_ready, rf_raddr1, rf_raddr2,
               alu_opcode, alu_funct3, alu_funct7, alu_imm, alu_shamt, alu_rs1, alu_rs2,
               rf_we, rf_waddr, rf_wdata, br_valid, br_taken,
               mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
               illegal, busy, retired_count
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Four-cycle issue sequencer for the shared ALU: accept, read operands,
// execute, then a single writeback / branch / memory / illegal strobe.
module alu_issue_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    alu_issue_ctrl_if.slave bus
);
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_live;
    logic [31:0]      r_instr;
    logic [WIDTH-1:0] r_op1;
    logic [WIDTH-1:0] r_op2;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_addr;
    logic [31:0]      r_retired;

    logic             w_accept;
    logic             w_is_r;
    logic             w_is_i;
    logic             w_is_br;
    logic             w_is_ld;
    logic             w_is_st;
    logic             w_legal;
    logic [11:0]      w_imm;
    logic [6:0]       w_f7;

    assign w_is_r  = (r_instr[6:0] == OP_R);
    assign w_is_i  = (r_instr[6:0] == OP_I);
    assign w_is_br = (r_instr[6:0] == OP_BR);
    assign w_is_ld = (r_instr[6:0] == OP_LD);
    assign w_is_st = (r_instr[6:0] == OP_ST);
    assign w_legal = w_is_r | w_is_i | w_is_br | w_is_ld | w_is_st;

    // r_live keeps instr_ready low until the first edge after reset release
    assign w_accept = bus.instr_valid & r_live & (r_state == S_IDLE);

    assign w_imm = (w_is_i || w_is_ld) ? r_instr[31:20] :
                   w_is_st             ? {r_instr[31:25], r_instr[11:7]} : '0;
    // Only shifts-right take funct7 on I-type, so ADDI never becomes a subtract
    assign w_f7  = (w_is_r || (w_is_i && r_instr[14:12] == 3'd5)) ? r_instr[31:25] : '0;

    assign bus.busy          = (r_state != S_IDLE);
    assign bus.retired_count = r_retired;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_live    <= 1'b0;
            r_instr   <= '0;
            r_op1     <= '0;
            r_op2     <= '0;
            r_res     <= '0;
            r_addr    <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
            if (w_accept) begin
                r_instr <= bus.instr;
            end
            if (r_state == S_READ) begin
                r_op1 <= bus.rf_rdata1;
                r_op2 <= bus.rf_rdata2;
            end
            if (r_state == S_EXEC) begin
                r_res  <= bus.alu_rd;
                r_addr <= bus.alu_mem_addr;
            end
            if (r_state == S_WB && w_legal) begin
                r_retired <= r_retired + 32'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        bus.instr_ready   = 1'b0;
        bus.rf_raddr1     = '0;
        bus.rf_raddr2     = '0;
        bus.alu_opcode    = '0;
        bus.alu_funct3    = '0;
        bus.alu_funct7    = '0;
        bus.alu_imm       = '0;
        bus.alu_shamt     = '0;
        bus.alu_rs1       = '0;
        bus.alu_rs2       = '0;
        bus.rf_we         = 1'b0;
        bus.rf_waddr      = '0;
        bus.rf_wdata      = '0;
        bus.br_valid      = 1'b0;
        bus.br_taken      = 1'b0;
        bus.mem_req_valid = 1'b0;
        bus.mem_req_we    = 1'b0;
        bus.mem_req_addr  = '0;
        bus.mem_req_wdata = '0;
        bus.illegal       = 1'b0;

        case (r_state)
            S_IDLE: begin
                bus.instr_ready = r_live;
                // Synchronous-read RF needs the address during the accept cycle
                if (r_live) begin
                    bus.rf_raddr1 = bus.instr[19:15];
                    bus.rf_raddr2 = bus.instr[24:20];
                end
                if (w_accept) begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ:  w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_WB;
            S_WB: begin
                w_state_nxt = S_IDLE;
                if (w_is_r || w_is_i) begin
                    if (r_instr[11:7] != 5'd0) begin
                        bus.rf_we    = 1'b1;
                        bus.rf_waddr = r_instr[11:7];
                        bus.rf_wdata = r_res;
                    end
                end else if (w_is_br) begin
                    bus.br_valid = 1'b1;
                    bus.br_taken = r_res[0];
                end else if (w_is_ld || w_is_st) begin
                    bus.mem_req_valid = 1'b1;
                    bus.mem_req_we    = w_is_st;
                    bus.mem_req_addr  = r_addr;
                    if (w_is_st) begin
                        bus.mem_req_wdata = r_op2;
                    end
                end else begin
                    bus.illegal = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (r_state != S_IDLE) begin
            bus.rf_raddr1 = r_instr[19:15];
            bus.rf_raddr2 = r_instr[24:20];
        end

        if (r_state == S_EXEC || r_state == S_WB) begin
            bus.alu_opcode = r_instr[6:0];
            bus.alu_funct3 = r_instr[14:12];
            bus.alu_funct7 = w_f7;
            bus.alu_imm    = w_imm;
            bus.alu_shamt  = r_instr[24:20];
            bus.alu_rs1    = r_op1;
            bus.alu_rs2    = r_op2;
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a register-file model and a small
// RV32 ALU model standing in for the surrounding core.
module tb_alu_issue_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [31:0] exp_ret = '0;
    logic [31:0] regs [32];

    alu_issue_ctrl_if #(.WIDTH(32)) bus ();

    alu_issue_ctrl #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus.rf_rdata1 <= regs[bus.rf_raddr1];
        bus.rf_rdata2 <= regs[bus.rf_raddr2];
    end

    // External ALU model: funct7[5] selects subtract / arithmetic shift
    always_comb begin
        logic [31:0] simm;
        simm = {{20{bus.alu_imm[11]}}, bus.alu_imm};
        bus.alu_rd = '0;
        bus.alu_mem_addr = bus.alu_rs1 + simm;
        case (bus.alu_opcode)
            7'h33: case (bus.alu_funct3)
                3'd0: bus.alu_rd = bus.alu_funct7[5] ? bus.alu_rs1 - bus.alu_rs2 : bus.alu_rs1 + bus.alu_rs2;
                3'd4: bus.alu_rd = bus.alu_rs1 ^ bus.alu_rs2;
                3'd6: bus.alu_rd = bus.alu_rs1 | bus.alu_rs2;
                3'd7: bus.alu_rd = bus.alu_rs1 & bus.alu_rs2;
                default: bus.alu_rd = '0;
            endcase
            7'h13: case (bus.alu_funct3)
                3'd0: bus.alu_rd = bus.alu_funct7[5] ? bus.alu_rs1 - simm : bus.alu_rs1 + simm;
                3'd1: bus.alu_rd = bus.alu_rs1 << bus.alu_shamt;
                3'd5: bus.alu_rd = bus.alu_funct7[5] ? 32'($signed(bus.alu_rs1) >>> bus.alu_shamt)
                                                     : bus.alu_rs1 >> bus.alu_shamt;
                default: bus.alu_rd = '0;
            endcase
            7'h63: case (bus.alu_funct3)
                3'd0: bus.alu_rd = {31'd0, bus.alu_rs1 == bus.alu_rs2};
                3'd1: bus.alu_rd = {31'd0, bus.alu_rs1 != bus.alu_rs2};
                default: bus.alu_rd = '0;
            endcase
            default: bus.alu_rd = '0;
        endcase
    end

    typedef struct {
        logic [31:0] ins;
        logic [3:0]  strb;   // {rf_we, br_valid, mem_req_valid, illegal}
        logic        brt;
        logic        memwe;
        logic [4:0]  waddr;
        logic [31:0] data;   // rf_wdata or mem_req_addr
        logic [31:0] mwdata;
        logic [11:0] imm;
        logic [6:0]  f7;
        logic        ret;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [31:0] ins);
        int unsigned n;
        n = 0;
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr = ins;
        while (!bus.instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: instr_ready never rose for 0x%08h", ins);
        end
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
    endtask

    task automatic apply(input vec_t v, input int idx);
        issue(v.ins);
        @(posedge clk);
        @(posedge clk);
        #1;
        check($sformatf("v%0d_strobes", idx),
              {28'd0, bus.rf_we, bus.br_valid, bus.mem_req_valid, bus.illegal}, {28'd0, v.strb});
        check($sformatf("v%0d_ready_in_wb", idx), {31'd0, bus.instr_ready}, 32'd0);
        if (v.strb[3]) begin
            check($sformatf("v%0d_waddr", idx), {27'd0, bus.rf_waddr}, {27'd0, v.waddr});
            check($sformatf("v%0d_wdata", idx), bus.rf_wdata, v.data);
        end
        if (v.strb[2]) check($sformatf("v%0d_br_taken", idx), {31'd0, bus.br_taken}, {31'd0, v.brt});
        if (v.strb[1]) begin
            check($sformatf("v%0d_mem_we", idx), {31'd0, bus.mem_req_we}, {31'd0, v.memwe});
            check($sformatf("v%0d_mem_addr", idx), bus.mem_req_addr, v.data);
            if (v.memwe) check($sformatf("v%0d_mem_wdata", idx), bus.mem_req_wdata, v.mwdata);
        end
        check($sformatf("v%0d_imm", idx), {20'd0, bus.alu_imm}, {20'd0, v.imm});
        check($sformatf("v%0d_funct7", idx), {25'd0, bus.alu_funct7}, {25'd0, v.f7});
        if (v.ret) exp_ret++;
        @(posedge clk);
        #1;
        check($sformatf("v%0d_retired", idx), bus.retired_count, exp_ret);
        check($sformatf("v%0d_strobes_after", idx),
              {28'd0, bus.rf_we, bus.br_valid, bus.mem_req_valid, bus.illegal}, 32'd0);
        check($sformatf("v%0d_ready_after", idx), {31'd0, bus.instr_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = '0;
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        regs[7] = 32'h8000_0000;
        bus.instr_valid = 1'b0;
        bus.instr = 32'h002081B3;

        vecs[0]  = '{32'h002081B3, 4'b1000, 1'b0, 1'b0, 5'd3, 32'd12,        32'd0, 12'h000, 7'h00, 1'b1};
        vecs[1]  = '{32'h40208233, 4'b1000, 1'b0, 1'b0, 5'd4, 32'hFFFFFFFE,  32'd0, 12'h000, 7'h20, 1'b1};
        vecs[2]  = '{32'h00108013, 4'b0000, 1'b0, 1'b0, 5'd0, 32'd0,         32'd0, 12'h001, 7'h00, 1'b1};
        vecs[3]  = '{32'h00108063, 4'b0100, 1'b1, 1'b0, 5'd0, 32'd0,         32'd0, 12'h000, 7'h00, 1'b1};
        vecs[4]  = '{32'h00208063, 4'b0100, 1'b0, 1'b0, 5'd0, 32'd0,         32'd0, 12'h000, 7'h00, 1'b1};
        vecs[5]  = '{32'h0080A283, 4'b0010, 1'b0, 1'b0, 5'd0, 32'd13,        32'd0, 12'h008, 7'h00, 1'b1};
        vecs[6]  = '{32'h0020A623, 4'b0010, 1'b0, 1'b1, 5'd0, 32'd17,        32'd7, 12'h00C, 7'h00, 1'b1};
        vecs[7]  = '{32'hFE20AE23, 4'b0010, 1'b0, 1'b1, 5'd0, 32'd1,         32'd7, 12'hFFC, 7'h00, 1'b1};
        vecs[8]  = '{32'h0000007F, 4'b0001, 1'b0, 1'b0, 5'd0, 32'd0,         32'd0, 12'h000, 7'h00, 1'b0};
        vecs[9]  = '{32'h4043D313, 4'b1000, 1'b0, 1'b0, 5'd6, 32'hF8000000,  32'd0, 12'h404, 7'h20, 1'b1};
        vecs[10] = '{32'hC0008413, 4'b1000, 1'b0, 1'b0, 5'd8, 32'hFFFFFC05,  32'd0, 12'hC00, 7'h00, 1'b1};

        // Power-on reset: everything low, ready rises one edge after release
        #12;
        check("rst_ready", {31'd0, bus.instr_ready}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_retired", bus.retired_count, 32'd0);
        check("rst_raddr1", {27'd0, bus.rf_raddr1}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rel_ready_before_edge", {31'd0, bus.instr_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("rel_ready_after_edge", {31'd0, bus.instr_ready}, 32'd1);

        for (int i = 0; i < 11; i++) apply(vecs[i], i);

        // Back-to-back valid: ready once every 4 cycles, three accepts in 12
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr = 32'h002081B3;
        for (int k = 0; k < 12; k++) begin
            check($sformatf("b2b_ready_c%0d", k), {31'd0, bus.instr_ready}, {31'd0, (k % 4) == 0});
            @(negedge clk);
        end
        bus.instr_valid = 1'b0;
        exp_ret += 32'd3;
        check("b2b_retired", bus.retired_count, exp_ret);

        // Reset while an ADD sits in EXEC: dropped with no strobe
        issue(32'h002081B3);
        @(posedge clk);
        #1;
        check("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_ready", {31'd0, bus.instr_ready}, 32'd0);
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_rst_alu_rs1", bus.alu_rs1, 32'd0);
        check("mid_rst_alu_opcode", {25'd0, bus.alu_opcode}, 32'd0);
        check("mid_rst_retired", bus.retired_count, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("mid_rst_we_c%0d", k), {31'd0, bus.rf_we}, 32'd0);
        end
        rst = 1'b1;
        exp_ret = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("post_rst_we_c%0d", k), {31'd0, bus.rf_we}, 32'd0);
        end
        apply(vecs[0], 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Multi-cycle issue sequencer that owns the shared ALU in the RISC-V core. It accepts one 32-bit instruction per valid/ready handshake and decodes the ALU control fields and immediate. It reads operands from the synchronous-read register file, drives the combinational ALU, and then either writes the result back, reports a branch decision, or issues a memory request. It sits between instruction fetch and the register file, memory port and branch unit.

Parameters:
WIDTH, 32, datapath width of operands and results

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset; asynchronous, active-low
instr_valid  in  1  fetch offers an instruction
instr_ready  out  1  controller accepts an instruction this cycle
instr  in  32  instruction word
rf_raddr1  out  5  register file read address, rs1 (instr[19:15])
rf_raddr2  out  5  register file read address, rs2 (instr[24:20])
rf_rdata1  in  WIDTH  rs1 data, valid one cycle after address
rf_rdata2  in  WIDTH  rs2 data, valid one cycle after address
alu_opcode  out  7  ALU opcode
alu_funct3  out  3  ALU funct3
alu_funct7  out  7  ALU funct7
alu_imm  out  12  ALU immediate
alu_shamt  out  5  ALU shift amount
alu_rs1  out  WIDTH  ALU operand 1
alu_rs2  out  WIDTH  ALU operand 2
alu_rd  in  WIDTH  ALU result
alu_mem_addr  in  WIDTH  ALU address result
rf_we  out  1  register write strobe
rf_waddr  out  5  write address (instr[11:7])
rf_wdata  out  WIDTH  write data
br_valid  out  1  branch decision strobe
br_taken  out  1  branch outcome, qualified by br_valid
mem_req_valid  out  1  memory request strobe
mem_req_we  out  1  1 = store, 0 = load
mem_req_addr  out  WIDTH  memory address
mem_req_wdata  out  WIDTH  store data (rs2)
illegal  out  1  unsupported-opcode strobe
busy  out  1  high in every state except IDLE
retired_count  out  32  count of instructions completed without illegal

Behaviour:
- FSM states: IDLE -> READ -> EXEC -> WB -> IDLE. All transitions are unconditional except IDLE.
- IDLE: instr_ready=1. On instr_valid & instr_ready, latch instr, drive rf_raddr1/2 from it, and go to READ. With no valid, stay in IDLE.
- READ: capture rf_rdata1/2 into operand registers.
- EXEC: alu_rs1/alu_rs2 driven from operand registers. alu_opcode/funct3/funct7/imm/shamt driven from the latched instruction. At end of cycle, capture alu_rd and alu_mem_addr.
- WB: exactly one strobe, one cycle wide, selected by opcode:
  - 0110011 / 0010011: rf_we=1 with rf_wdata=captured alu_rd, but only when rd != 0. rd = 0 gives no write and still retires.
  - 1100011: br_valid=1, br_taken=captured alu_rd[0].
  - 0000011: mem_req_valid=1, mem_req_we=0.
  - 0100011: mem_req_valid=1, mem_req_we=1, mem_req_wdata=rs2.
  - Any other opcode: illegal=1, no other strobe, not retired.
- Fixed timing: 4 cycles per instruction; the WB strobe appears 3 cycles after the accept edge. No overlap; instr_ready is low in READ, EXEC and WB.
- Immediate decode:
  - I-type and load: alu_imm=instr[31:20].
  - Store: alu_imm={instr[31:25],instr[11:7]}.
  - Branch and R-type: alu_imm=0.
  - alu_shamt=instr[24:20] for all opcodes.
- Funct7 decode:
  - R-type: alu_funct7=instr[31:25].
  - I-type with funct3=5: alu_funct7=instr[31:25].
  - I-type with any other funct3: alu_funct7=0, so ADDI never subtracts.
  - All other opcodes: alu_funct7=0.
- ALU control outputs and operands hold their values from EXEC through WB; they are 0 in IDLE.
- retired_count increments by 1 in each non-illegal WB and wraps 0xFFFFFFFF -> 0.
- Reset (rst low, any state): immediate return to IDLE. All outputs 0, including instr_ready, strobes and retired_count. An in-flight instruction is dropped with no strobe. instr_ready rises on the first clk edge after rst deasserts.

Test Plan:
- x1=5, x2=7; ADD x3,x1,x2 (0x002081B3) -> 3 cycles after accept: rf_we=1, rf_waddr=3, rf_wdata=12; retired_count=1.
- SUB x4,x1,x2 (0x40208233) -> rf_wdata=0xFFFFFFFE, rf_waddr=4. ADDI x0,x1,1 (0x00108013) -> no rf_we, retired_count increments.
- BEQ x1,x1 (0x00108063) -> br_valid=1, br_taken=1, rf_we=0. LW x5,8(x1) (0x0080A283) -> mem_req_valid=1, mem_req_we=0, mem_req_addr=13.
- Opcode 0x7F -> illegal=1 for one cycle, no other strobe, retired_count unchanged. Back-to-back instr_valid -> instr_ready high exactly once every 4 cycles.
- Assert rst during EXEC of an ADD -> no rf_we, all outputs 0, retired_count=0. Next accepted instruction completes normally.
